// File: rtl/adds_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package adds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; a single-digit operation still gets a 1-bit counter.
  function automatic int cnt_w(input int width, input int digit);
    return (width / digit) > 1 ? $clog2(width / digit) : 1;
  endfunction

  // Signed min (sign=1) or max (sign=0) for a given width, right-aligned in 64 bits.
  function automatic logic [63:0] sat_value(input int width, input logic sign);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return sign ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/adds_serial_if.sv
// Operation request / result bundle for adds_serial, plus FSM state for observation.
interface adds_serial_if
  import adds_pkg::*;
#(
  parameter int WIDTH = 16
);
  // Handshake: start is sampled only while busy is low; operands, m and sat are
  // captured on that same edge. done pulses for one cycle when s and the flags
  // update, and busy stays high from the accept edge until the cycle after done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             sat;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             v;
  logic             z;
  logic             neg;
  state_t           state;

  modport master (
    output start, a, b, m, sat,
    input  busy, done, s, cout, v, z, neg, state
  );

  modport slave (
    input  start, a, b, m, sat,
    output busy, done, s, cout, v, z, neg, state
  );

endinterface

// File: rtl/adds_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module adds_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adds_serial.sv
// Digit-serial signed/unsigned add/subtract with carry, overflow, zero and negative
// flags and optional signed saturation. WIDTH must be a multiple of DIGIT, WIDTH <= 64.
module adds_serial
  import adds_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  adds_serial_if.slave bus
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] nb_sr;
  logic [WIDTH-1:0] r_sr;
  logic             carry;
  logic             a_sign;
  logic             sat_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic [WIDTH-1:0] raw;
  logic             v_raw;
  logic [WIDTH-1:0] s_fin;

  adds_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (nb_sr[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // Result shift register with the current digit's sum folded in at the top.
  if (DIGIT == WIDTH) begin : g_one_digit
    assign raw = dsum;
  end else begin : g_multi_digit
    assign raw = {dsum, r_sr[WIDTH-1:DIGIT]};
  end

  // Only meaningful on the last digit, where cmsb is the carry into bit WIDTH-1.
  always_comb begin
    v_raw = dcmsb ^ dcout;
    s_fin = (sat_q && v_raw) ? WIDTH'(sat_value(WIDTH, a_sign)) : raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      nb_sr    <= '0;
      r_sr     <= '0;
      carry    <= 1'b0;
      a_sign   <= 1'b0;
      sat_q    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.s    <= '0;
      bus.cout <= 1'b0;
      bus.v    <= 1'b0;
      bus.z    <= 1'b0;
      bus.neg  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            nb_sr    <= bus.b ^ {WIDTH{bus.m}};
            carry    <= bus.m;
            a_sign   <= bus.a[WIDTH-1];
            sat_q    <= bus.sat;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          nb_sr <= nb_sr >> DIGIT;
          r_sr  <= raw;
          carry <= dcout;
          if (cnt == LAST) begin
            bus.s    <= s_fin;
            bus.cout <= dcout;
            bus.v    <= v_raw;
            bus.z    <= (s_fin == '0);
            bus.neg  <= s_fin[WIDTH-1];
            bus.done <= 1'b1;
            state    <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.state = state;

endmodule

// File: doc/adds_serial.md
Name: adds_serial

Overview:
- Parametrised digit-serial signed/unsigned add/subtract unit with a START/BUSY/DONE handshake.
- Processes DIGIT bits per clock over a WIDTH-bit operand pair.
- Reports carry-out, signed overflow, zero and negative flags, with optional signed saturation.
- Successor to the 4-bit combinational add/sub unit; used where wide operands need a small adder footprint and multi-cycle latency is acceptable.

Parameters:
WIDTH, 16, operand/result width in bits; must be at least 2.
DIGIT, 4, bits processed per clock; must satisfy 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0.
(derived) NDIG = WIDTH/DIGIT, digits per operation; CW = max(1, clog2(NDIG)), digit counter width.

Ports:
CLK    in   1      clock, rising edge.
RST_N  in   1      asynchronous reset, active low.
START  in   1      operation request; sampled only in IDLE.
A      in   WIDTH  operand A, captured when START is accepted.
B      in   WIDTH  operand B, captured when START is accepted.
M      in   1      mode, captured with operands: 0 = A+B, 1 = A-B (B inverted, carry-in 1).
SAT    in   1      captured with operands: 1 = clamp signed overflow to the signed min/max.
BUSY   out  1      high whenever state is not IDLE.
DONE   out  1      one-cycle pulse; results valid and updated in this cycle.
S      out  WIDTH  result, registered, held until the next DONE.
COUT   out  1      raw carry out of the MSB (unsigned carry for add, no-borrow for sub).
V      out  1      signed overflow (carry into MSB XOR carry out of MSB).
Z      out  1      final S == 0, evaluated after saturation.
NEG    out  1      final S[WIDTH-1], evaluated after saturation.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; BUSY=0, DONE=0, S=0, COUT=0, V=0, Z=0, NEG=0; shift registers, carry and counter cleared.
- Reset asserted mid-operation aborts it: no DONE is produced, and the previous results are lost (zeroed).
- States: IDLE, RUN, FIN.
  - IDLE: on an edge with START=1, latch A, B^{WIDTH{M}}, M and SAT; carry register <= M; cnt <= 0; go to RUN.
  - RUN: each edge adds the low DIGIT bits of the A and NB shift registers plus the carry register. Shift the DIGIT-bit sum into the top of the result shift register, shift the operands right by DIGIT, update carry, cnt++.
  - RUN to FIN: the edge with cnt == NDIG-1 completes the last digit. On that edge, write S/COUT/V/Z/NEG and go to FIN.
  - FIN: DONE=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: START accepted at edge k, results and DONE visible after edge k+NDIG, back in IDLE after edge k+NDIG+1. Throughput: one op per NDIG+2 cycles.
- START while in RUN or FIN is ignored, with no queueing. START held high is re-accepted on the first IDLE edge.
- Operand inputs may change freely after the accept edge.
- Overflow: V uses the carry into bit WIDTH-1. When DIGIT > 1 this is taken from inside the last digit's adder, not from the digit boundary.
- Saturation: if SAT=1 and V=1, then S = captured A[WIDTH-1] ? {1,0...0} : {0,1...1}. This holds for both add and sub. COUT and V keep their raw values.
- DIGIT == WIDTH degenerates to a single RUN cycle (NDIG=1, cnt stays 0). DIGIT == 1 is bit-serial.
- S and the flags never change except on the completion edge or on reset.

Decomposition:
- Shared package adds_pkg:
  - state enum (IDLE/RUN/FIN);
  - function sat_value(width, sign) returning signed max/min;
  - localparam helpers for NDIG/CW.
- Sub-module adds_digit: combinational DIGIT-bit ripple adder.
  - Inputs a, b, cin. Outputs sum, cout, and cmsb (carry into the digit's top bit).
  - Built from the existing FA full-adder cell.
- adds_serial holds the FSM, shift registers, counter and output registers.

Test Plan:
- WIDTH=16 DIGIT=4, A=0x1234 B=0x4321 M=0 SAT=0 -> DONE exactly 4 edges after accept; S=0x5555, COUT=0, V=0, Z=0, NEG=0; BUSY high for 5 cycles.
- A=0x0005 B=0x0005 M=1 -> S=0x0000, COUT=1, V=0, Z=1, NEG=0.
- A=0x7FFF B=0x0001 M=0: SAT=0 -> S=0x8000, V=1, NEG=1, COUT=0; SAT=1 -> S=0x7FFF, V=1, NEG=0.
- A=0x8000 B=0x0001 M=1 SAT=1 -> raw 0x7FFF saturates to S=0x8000; V=1, COUT=1, NEG=1, Z=0.
- START pulsed during RUN and in the DONE cycle -> ignored, S unchanged; START held high -> new op accepted on the first IDLE edge. Repeat the first case with DIGIT=1 (DONE after 16) and DIGIT=16 (DONE after 1); S=0x5555 in both.
- RST_N driven low 2 cycles into RUN -> all outputs 0 immediately, no DONE pulse; the next START completes normally.
